// File: rtl/grf_wb_arbiter_pkg.sv
// Shared widths, constants and the buffered write-back entry format for the
// GRF write-port arbiter.
package grf_wb_arbiter_pkg;

  localparam int REG_AW = 5;
  localparam int DATA_W = 32;
  localparam int PC_W   = 32;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_AW-1:0] a3;
    logic [DATA_W-1:0] wd;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// DEPTH-entry FIFO holding buffered M-port write-backs, with per-slot valid
// and destination taps so the top can answer hazard queries.
module wb_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           i_push,
  input  logic [ENTRY_W-1:0]             i_entry,
  input  logic                           i_pop,
  output logic [ENTRY_W-1:0]             o_head,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [CW-1:0]                  o_count,
  output logic [DEPTH-1:0]               o_valid,
  output logic [DEPTH-1:0][REG_AW-1:0]   o_a3
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t        r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

  // Guard locally too, so a misbehaving caller cannot corrupt the pointers.
  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_valid = r_valid;

  always_comb begin
    o_a3 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      o_a3[i] = r_mem[i].a3;
    end
  end

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wb_entry_t'(i_entry);
    end
  end

  // Pointers are PW bits wide, so increments wrap modulo DEPTH on their own.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Shares the GRF write port between the pipeline (absolute priority) and a
// buffered long-latency M port, with hazard queries and starvation stall.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              P_WE,
  input  logic [4:0]        P_A3,
  input  logic [31:0]       P_WD,
  input  logic [31:0]       P_PC,
  input  logic              M_Valid,
  output logic              M_Ready,
  input  logic [4:0]        M_A3,
  input  logic [31:0]       M_WD,
  input  logic [31:0]       M_PC,
  input  logic [4:0]        Q_A1,
  input  logic [4:0]        Q_A2,
  output logic              Q_Busy1,
  output logic              Q_Busy2,
  output logic              Stall_Req,
  output logic [CW-1:0]     Count,
  output logic              Grf_WE,
  output logic [4:0]        Grf_A3,
  output logic [31:0]       Grf_WD,
  output logic [31:0]       Grf_PC
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  // Handshake: an M result transfers on a posedge where M_Valid && M_Ready.
  // M_Ready reflects only the registered full flag; a pop in the same cycle
  // does not free a slot early. P is never back-pressured.

  logic                          w_p_act;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_full;
  logic                          w_empty;
  wb_entry_t                     w_m_entry;
  wb_entry_t                     w_head;
  logic [DEPTH-1:0]              w_valid;
  logic [DEPTH-1:0][REG_AW-1:0]  w_a3;
  logic [SW-1:0]                 r_starve;

  assign w_p_act   = P_WE && (P_A3 != REG_ZERO);
  assign M_Ready   = !Reset && !w_full;
  assign w_push    = M_Valid && M_Ready && (M_A3 != REG_ZERO);
  assign w_pop     = !Reset && !w_p_act && !w_empty;
  assign w_m_entry = '{pc: M_PC, a3: M_A3, wd: M_WD};

  wb_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_push  (w_push),
    .i_entry (w_m_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (Count),
    .o_valid (w_valid),
    .o_a3    (w_a3)
  );

  always_comb begin
    Grf_WE = 1'b0;
    Grf_A3 = '0;
    Grf_WD = '0;
    Grf_PC = '0;
    if (!Reset) begin
      if (w_p_act) begin
        Grf_WE = 1'b1;
        Grf_A3 = P_A3;
        Grf_WD = P_WD;
        Grf_PC = P_PC;
      end else if (!w_empty) begin
        Grf_WE = 1'b1;
        Grf_A3 = w_head.a3;
        Grf_WD = w_head.wd;
        Grf_PC = w_head.pc;
      end
    end
  end

  // The head being popped is still a valid slot this cycle, so it stays busy.
  always_comb begin
    Q_Busy1 = 1'b0;
    Q_Busy2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_a3[i] == Q_A1)) Q_Busy1 = 1'b1;
      if (w_valid[i] && (w_a3[i] == Q_A2)) Q_Busy2 = 1'b1;
    end
    if (Reset || (Q_A1 == REG_ZERO)) Q_Busy1 = 1'b0;
    if (Reset || (Q_A2 == REG_ZERO)) Q_Busy2 = 1'b0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_starve <= '0;
    end else if (w_pop || w_empty) begin
      r_starve <= '0;
    end else if (w_p_act && (r_starve != SW'(STARVE_LIMIT))) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  assign Stall_Req = !Reset && (r_starve == SW'(STARVE_LIMIT));

endmodule
